// File: rtl/activation_rr_scheduler.sv
// activation_rr_scheduler
// Shares one in-order activation datapath between NUM_REQ requesters.
// Issue side: a round-robin arbiter picks a requester and forwards its beat.
// The grant is held while the datapath stalls the beat.
// Return side: a tag FIFO remembers which requester issued each beat.
// Results are steered back to that requester in issue order.
// TAG_DEPTH must be a power of two, at least 2, so the FIFO pointers wrap naturally.
module activation_rr_scheduler #(
  parameter int NUM_REQ        = 2,
  parameter int PARALLELISM    = 2,
  parameter int DATA_IN_WIDTH  = 16,
  parameter int DATA_OUT_WIDTH = 48,
  parameter int TAG_DEPTH      = 4
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_REQ*PARALLELISM*DATA_IN_WIDTH-1:0]  req_data_in,
  input  logic [NUM_REQ-1:0]                            req_data_in_valid,
  output logic [NUM_REQ-1:0]                            req_data_in_ready,
  output logic [NUM_REQ*PARALLELISM*DATA_OUT_WIDTH-1:0] req_data_out,
  output logic [NUM_REQ-1:0]                            req_data_out_valid,
  input  logic [NUM_REQ-1:0]                            req_data_out_ready,
  output logic [PARALLELISM*DATA_IN_WIDTH-1:0]          act_data_in,
  output logic                                          act_data_in_valid,
  input  logic                                          act_data_in_ready,
  input  logic [PARALLELISM*DATA_OUT_WIDTH-1:0]         act_data_out,
  input  logic                                          act_data_out_valid,
  output logic                                          act_data_out_ready,
  output logic [$clog2(TAG_DEPTH):0]                    in_flight,
  output logic                                          orphan_err
);

  localparam int IW  = PARALLELISM * DATA_IN_WIDTH;
  localparam int OW  = PARALLELISM * DATA_OUT_WIDTH;
  localparam int IDW = $clog2(NUM_REQ);
  localparam int PW  = $clog2(TAG_DEPTH);
  localparam int CW  = $clog2(TAG_DEPTH) + 1;

  // Arbitration state
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic           lock_q, lock_d;
  logic [IDW-1:0] lock_id_q, lock_id_d;

  // Tag FIFO state
  logic [IDW-1:0] tag_mem_q [TAG_DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           orphan_q, orphan_d;

  // Combinational helpers
  logic [IW-1:0]  req_slice [NUM_REQ];
  logic [IDW-1:0] arb_id;
  logic           arb_found;
  logic [IDW-1:0] grant_id;
  logic           grant_vld;
  logic           can_issue;
  logic           issue_fire;
  logic           fifo_nempty;
  logic [IDW-1:0] head_id;
  logic           pop_fire;

  genvar gi;

  // Per-requester slicing and fan-out of the shared return bus
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_slice[gi]                = req_data_in[gi*IW +: IW];
      assign req_data_out[gi*OW +: OW]    = act_data_out;
      assign req_data_in_ready[gi]        = issue_fire && (grant_id == IDW'(gi));
      assign req_data_out_valid[gi]       = fifo_nempty && act_data_out_valid &&
                                            (head_id == IDW'(gi));
    end
  endgenerate

  // Round-robin search starting at rr_ptr; first valid requester wins
  always_comb begin
    int idx;
    idx       = 0;
    arb_found = 1'b0;
    arb_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!arb_found && req_data_in_valid[IDW'(idx)]) begin
        arb_found = 1'b1;
        arb_id    = IDW'(idx);
      end
    end
  end

  // Issue path. Reset gating keeps every handshake output low while rst is
  // held, even though the requester valids may still be high.
  assign can_issue         = rst && (count_q < CW'(TAG_DEPTH));
  assign grant_id          = lock_q ? lock_id_q : arb_id;
  assign grant_vld         = lock_q | arb_found;
  assign act_data_in_valid = can_issue && grant_vld;
  assign act_data_in       = req_slice[grant_id];
  assign issue_fire        = act_data_in_valid && act_data_in_ready;

  // Return path. It depends only on the FIFO head, never on the issue side.
  assign fifo_nempty        = (count_q != '0);
  assign head_id            = tag_mem_q[rd_ptr_q];
  assign act_data_out_ready = fifo_nempty && req_data_out_ready[head_id];
  assign pop_fire           = act_data_out_valid && act_data_out_ready;

  assign in_flight  = count_q;
  assign orphan_err = orphan_q;

  // Next-state logic for the grant lock, round-robin pointer and tag FIFO
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    orphan_d  = orphan_q | (act_data_out_valid && !fifo_nempty);

    if (issue_fire) begin
      lock_d   = 1'b0;
      rr_ptr_d = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end else if (act_data_in_valid) begin
      // Beat presented but stalled: freeze the grant until it is accepted
      lock_d    = 1'b1;
      lock_id_d = grant_id;
    end

    if (pop_fire) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({issue_fire, pop_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control registers; reset drops all outstanding tags at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q  <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      orphan_q  <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      orphan_q  <= orphan_d;
    end
  end

  // Tag storage. Entries are only read while counted as valid, so no reset is needed.
  always_ff @(posedge clk) begin
    if (issue_fire) begin
      tag_mem_q[wr_ptr_q] <= grant_id;
    end
  end

endmodule

// File: tb/tb_activation_rr_scheduler.sv
// Testbench for activation_rr_scheduler.
// Directed stimulus pushes the expected issue and return transactions into queues.
// Monitors pop and compare those queues on every DUT handshake.
module tb_activation_rr_scheduler;

  localparam int NR  = 2;
  localparam int PAR = 2;
  localparam int DIW = 16;
  localparam int DOW = 48;
  localparam int TD  = 4;
  localparam int IW  = PAR * DIW;
  localparam int OW  = PAR * DOW;
  localparam int CW  = $clog2(TD) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NR*IW-1:0]  req_data_in;
  logic [NR-1:0]     req_data_in_valid;
  logic [NR-1:0]     req_data_in_ready;
  logic [NR*OW-1:0]  req_data_out;
  logic [NR-1:0]     req_data_out_valid;
  logic [NR-1:0]     req_data_out_ready;
  logic [IW-1:0]     act_data_in;
  logic              act_data_in_valid;
  logic              act_data_in_ready;
  logic [OW-1:0]     act_data_out;
  logic              act_data_out_valid;
  logic              act_data_out_ready;
  logic [CW-1:0]     in_flight;
  logic              orphan_err;

  logic [IW-1:0]     rdat [NR];

  typedef struct {
    int            id;
    logic [OW-1:0] data;
  } exp_t;

  exp_t exp_issue[$];
  exp_t exp_ret[$];
  int   tag_model[$];

  int checks = 0;
  int errors = 0;
  int ret_seq = 0;

  int   mon_gid;
  int   mon_rid;
  exp_t mon_e;

  assign req_data_in = {rdat[1], rdat[0]};

  always #5 clk = ~clk;

  activation_rr_scheduler #(
    .NUM_REQ(NR), .PARALLELISM(PAR), .DATA_IN_WIDTH(DIW),
    .DATA_OUT_WIDTH(DOW), .TAG_DEPTH(TD)
  ) dut (
    .clk(clk), .rst(rst),
    .req_data_in(req_data_in),
    .req_data_in_valid(req_data_in_valid),
    .req_data_in_ready(req_data_in_ready),
    .req_data_out(req_data_out),
    .req_data_out_valid(req_data_out_valid),
    .req_data_out_ready(req_data_out_ready),
    .act_data_in(act_data_in),
    .act_data_in_valid(act_data_in_valid),
    .act_data_in_ready(act_data_in_ready),
    .act_data_out(act_data_out),
    .act_data_out_valid(act_data_out_valid),
    .act_data_out_ready(act_data_out_ready),
    .in_flight(in_flight),
    .orphan_err(orphan_err)
  );

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [NR-1:0] v);
    int r;
    r = 99;
    for (int i = 0; i < NR; i++) begin
      if (v[i]) r = (r == 99) ? i : 98;
    end
    return r;
  endfunction

  function automatic logic [OW-1:0] mk_ret(input int n);
    return {32'hCAFE_0000 + 32'(n), 32'h1234_5678, 32'(n) ^ 32'h00FF_FF00};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Expect requester id to win the next issue handshake with its current data
  task automatic issue_exp(input int id);
    exp_t e;
    e.id   = id;
    e.data = OW'(rdat[id]);
    exp_issue.push_back(e);
    tag_model.push_back(id);
  endtask

  // Present one datapath result; it belongs to the oldest outstanding tag
  task automatic ret_exp();
    exp_t e;
    act_data_out       = mk_ret(ret_seq);
    act_data_out_valid = 1'b1;
    e.id   = tag_model.pop_front();
    e.data = mk_ret(ret_seq);
    exp_ret.push_back(e);
    ret_seq++;
  endtask

  // Monitor: sample handshakes half a cycle before the edge that completes them
  always @(negedge clk) begin
    if (rst) begin
      if (act_data_in_valid && act_data_in_ready) begin
        mon_gid = onehot_idx(req_data_in_ready);
        if (exp_issue.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL issue_unexpected: got id %0d expected no issue", mon_gid);
        end else begin
          mon_e = exp_issue.pop_front();
          chk("issue_id", OW'(mon_gid), OW'(mon_e.id));
          chk("issue_data", OW'(act_data_in), mon_e.data);
          $display("issue  id=%0d data=%h", mon_gid, act_data_in);
        end
      end
      if (|(req_data_out_valid & req_data_out_ready)) begin
        mon_rid = onehot_idx(req_data_out_valid & req_data_out_ready);
        if (exp_ret.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ret_unexpected: got id %0d expected no return", mon_rid);
        end else begin
          mon_e = exp_ret.pop_front();
          chk("ret_id", OW'(mon_rid), OW'(mon_e.id));
          chk("ret_ack", OW'(act_data_out_ready), OW'(1));
          if (mon_rid < NR) begin
            chk("ret_data", req_data_out[mon_rid*OW +: OW], mon_e.data);
          end
          $display("return id=%0d data=%h", mon_rid, act_data_out);
        end
      end
    end
  end

  // Time bound on the whole run
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  // Directed stimulus
  initial begin
    rdat[0]            = 32'h0A0A_0A0A;
    rdat[1]            = 32'h0B0B_0B0B;
    req_data_in_valid  = 2'b11;
    act_data_in_ready  = 1'b1;
    req_data_out_ready = 2'b11;
    act_data_out_valid = 1'b1;
    act_data_out       = '0;

    // Reset state with busy inputs
    cyc();
    cyc();
    chk("rst_inflight", OW'(in_flight), OW'(0));
    chk("rst_orphan", OW'(orphan_err), OW'(0));
    chk("rst_act_in_valid", OW'(act_data_in_valid), OW'(0));
    chk("rst_req_in_ready", OW'(req_data_in_ready), OW'(0));
    chk("rst_act_out_ready", OW'(act_data_out_ready), OW'(0));
    chk("rst_req_out_valid", OW'(req_data_out_valid), OW'(0));
    act_data_out_valid = 1'b0;
    req_data_in_valid  = 2'b00;
    cyc();
    rst = 1'b1;

    // Both requesters valid: grants alternate 0,1,0,1 and fill the FIFO
    req_data_in_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      rdat[0] = 32'hA000_0000 + 32'(k);
      rdat[1] = 32'hB000_0000 + 32'(k);
      chk("fill_count", OW'(in_flight), OW'(k));
      issue_exp(k % 2);
      cyc();
    end
    settle();
    chk("full_count", OW'(in_flight), OW'(4));
    chk("full_act_valid", OW'(act_data_in_valid), OW'(0));
    chk("full_req_ready", OW'(req_data_in_ready), OW'(0));

    // Head requester 0 back-pressures the return
    req_data_out_ready = 2'b10;
    act_data_out       = mk_ret(999);
    act_data_out_valid = 1'b1;
    settle();
    chk("bp_act_ready", OW'(act_data_out_ready), OW'(0));
    chk("bp_req_valid", OW'(req_data_out_valid), OW'(1));
    cyc();
    chk("bp_hold", OW'(in_flight), OW'(4));

    // One return frees exactly one issue slot
    req_data_out_ready = 2'b01;
    ret_exp();
    cyc();
    act_data_out_valid = 1'b0;
    chk("one_free", OW'(in_flight), OW'(3));
    rdat[0] = 32'hA000_0004;
    settle();
    chk("slot_ready", OW'(req_data_in_ready), OW'(1));
    issue_exp(0);
    cyc();
    chk("refull_count", OW'(in_flight), OW'(4));
    settle();
    chk("refull_ready", OW'(req_data_in_ready), OW'(0));

    // Drain to two outstanding
    req_data_in_valid  = 2'b00;
    req_data_out_ready = 2'b11;
    for (int j = 0; j < 2; j++) begin
      ret_exp();
      cyc();
    end
    chk("drain2_count", OW'(in_flight), OW'(2));

    // Issue and return every cycle at two outstanding, wrapping the FIFO
    req_data_in_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      rdat[0] = 32'hA100_0000 + 32'(k);
      rdat[1] = 32'hB100_0000 + 32'(k);
      chk("steady_count", OW'(in_flight), OW'(2));
      issue_exp((k % 2 == 0) ? 1 : 0);
      ret_exp();
      cyc();
    end
    chk("steady_end", OW'(in_flight), OW'(2));
    req_data_in_valid = 2'b00;
    for (int j = 0; j < 2; j++) begin
      ret_exp();
      cyc();
    end
    act_data_out_valid = 1'b0;
    chk("drain0_count", OW'(in_flight), OW'(0));

    // Stall with requester 0 granted; requester 1 arrives but must wait
    rdat[0]           = 32'hC000_0000;
    rdat[1]           = 32'hD000_0000;
    req_data_in_valid = 2'b01;
    act_data_in_ready = 1'b0;
    settle();
    chk("lock_data0", OW'(act_data_in), OW'(32'hC000_0000));
    chk("lock_ready0", OW'(req_data_in_ready), OW'(0));
    cyc();
    req_data_in_valid = 2'b11;
    settle();
    chk("lock_data1", OW'(act_data_in), OW'(32'hC000_0000));
    chk("lock_valid1", OW'(act_data_in_valid), OW'(1));
    cyc();
    settle();
    chk("lock_data2", OW'(act_data_in), OW'(32'hC000_0000));
    cyc();
    act_data_in_ready = 1'b1;
    issue_exp(0);
    settle();
    chk("lock_release", OW'(req_data_in_ready), OW'(1));
    cyc();
    issue_exp(1);
    settle();
    chk("next_grant", OW'(req_data_in_ready), OW'(2));
    cyc();
    req_data_in_valid = 2'b01;
    rdat[0] = 32'hC000_0001;
    issue_exp(0);
    cyc();
    req_data_in_valid = 2'b00;
    chk("pre_rst_count", OW'(in_flight), OW'(3));

    // Asynchronous reset with three outstanding
    req_data_in_valid = 2'b11;
    #1;
    rst = 1'b0;
    act_data_out_valid = 1'b1;
    #1;
    chk("arst_inflight", OW'(in_flight), OW'(0));
    chk("arst_act_valid", OW'(act_data_in_valid), OW'(0));
    chk("arst_req_ready", OW'(req_data_in_ready), OW'(0));
    chk("arst_req_out_valid", OW'(req_data_out_valid), OW'(0));
    chk("arst_act_out_ready", OW'(act_data_out_ready), OW'(0));
    tag_model.delete();
    cyc();
    cyc();
    act_data_out_valid = 1'b0;
    rdat[0] = 32'hE000_0000;
    rdat[1] = 32'hF000_0000;
    rst = 1'b1;
    settle();
    chk("first_grant", OW'(req_data_in_ready), OW'(1));
    issue_exp(0);
    cyc();
    req_data_in_valid = 2'b00;
    chk("post_rst_count", OW'(in_flight), OW'(1));
    ret_exp();
    cyc();
    act_data_out_valid = 1'b0;
    chk("post_rst_drain", OW'(in_flight), OW'(0));

    // Result with nothing outstanding
    chk("orphan_clear", OW'(orphan_err), OW'(0));
    act_data_out       = mk_ret(777);
    act_data_out_valid = 1'b1;
    settle();
    chk("orphan_act_ready", OW'(act_data_out_ready), OW'(0));
    chk("orphan_req_valid", OW'(req_data_out_valid), OW'(0));
    cyc();
    act_data_out_valid = 1'b0;
    chk("orphan_set", OW'(orphan_err), OW'(1));
    cyc();
    cyc();
    cyc();
    chk("orphan_sticky", OW'(orphan_err), OW'(1));
    rst = 1'b0;
    #1;
    chk("orphan_reset", OW'(orphan_err), OW'(0));

    // Every expected transaction must have been observed
    chk("issue_queue_empty", OW'(exp_issue.size()), OW'(0));
    chk("ret_queue_empty", OW'(exp_ret.size()), OW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
